// File: rtl/round_1_enc_pipe_pkg.sv
// round_1_enc_pipe_pkg
// Shared constants and GF(2^8) helpers for the AES-128 round-1 encryption pipe.
// Provides the state geometry, xtime and multiply helpers, and a computed S-box.
// The S-box is the multiplicative inverse followed by the affine transform,
// so no lookup table has to be kept in sync with the standard.
package round_1_enc_pipe_pkg;

  localparam int AES_STATE_W  = 128;
  localparam int AES_NUM_BYTE = 16;
  localparam int AES_NUM_COL  = 4;
  localparam logic [7:0] AFFINE_C = 8'h63;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse is x^254 = prod x^(2^i), i=1..7; zero maps to zero naturally.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = x;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ AFFINE_C;
  endfunction

endpackage

// File: rtl/round_1_enc_pipe_obuf.sv
// round_1_enc_obuf
// Output FIFO for the round-1 pipe. The head entry is presented combinationally
// and forced to zero while empty, so 'valid' and 'head' change only on push/pop.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_data  write one entry (caller guarantees room)
//   pop              remove the head entry (caller guarantees non-empty)
//   valid, head      non-empty flag and head data (zero when empty)
//   count            current occupancy, used by the upstream credit logic
module round_1_enc_obuf
  import round_1_enc_pipe_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  // Pointers wrap at DEPTH, which need not be a power of two.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (pop)
      rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    if (push)
      wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (!push && pop)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible through count_reg.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign valid = (count_reg != '0);
  assign head  = valid ? mem_reg[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/round_1_enc_pipe.sv
// round_1_enc_pipe
// AES-128 encryption round 1 with valid/ready streaming:
//   AddRoundKey(KEY0) -> SubBytes (registered) -> ShiftRows -> MixColumns
//   -> AddRoundKey(KEY1) -> output FIFO.
// The SubBytes stage cannot stall, so acceptance is credit based: a block is
// taken only when the FIFO has room for it and for the one already in flight.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake; IN/KEY0/KEY1 sampled on transfer
//   IN, KEY0, KEY1        plaintext, cipher key, round-1 key
//   out_valid, out_ready  output handshake
//   OUT                   round-1 state, zero while out_valid is low
module round_1_enc_pipe
  import round_1_enc_pipe_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int FIFO_DEPTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY0,
  input  logic [BLOCK_LENGTH-1:0] KEY1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  logic                   xfer;
  logic                   pop;
  logic [AES_STATE_W-1:0] ark0;
  logic [AES_STATE_W-1:0] sub_next;
  logic [AES_STATE_W-1:0] sub_reg;
  logic [AES_STATE_W-1:0] key1_reg;
  logic                   v1_reg;
  logic                   alive_reg;
  logic [AES_STATE_W-1:0] mix_state;
  logic [AES_STATE_W-1:0] push_data;
  logic [CW-1:0]          fifo_count;
  logic [OW-1:0]          occupancy;

  assign xfer = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign ark0 = IN ^ KEY0;

  // Byte i of the state sits at bits [127-8i -: 8]; byte index = row + 4*col.
  genvar gi;
  generate
    for (gi = 0; gi < AES_NUM_BYTE; gi++) begin : g_sub
      assign sub_next[AES_STATE_W-1-8*gi -: 8] = sbox(ark0[AES_STATE_W-1-8*gi -: 8]);
    end

    // ShiftRows is pure wiring: row r of column c comes from column (c+r) mod 4.
    for (gi = 0; gi < AES_NUM_COL; gi++) begin : g_col
      localparam int B0 = 0 + 4 * ((gi + 0) % 4);
      localparam int B1 = 1 + 4 * ((gi + 1) % 4);
      localparam int B2 = 2 + 4 * ((gi + 2) % 4);
      localparam int B3 = 3 + 4 * ((gi + 3) % 4);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] m0, m1, m2, m3;
      assign a0 = sub_reg[AES_STATE_W-1-8*B0 -: 8];
      assign a1 = sub_reg[AES_STATE_W-1-8*B1 -: 8];
      assign a2 = sub_reg[AES_STATE_W-1-8*B2 -: 8];
      assign a3 = sub_reg[AES_STATE_W-1-8*B3 -: 8];
      // MixColumns matrix rows {2,3,1,1} rotated; 3*a = xtime(a)^a.
      assign m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      assign mix_state[AES_STATE_W-1-32*gi -: 32] = {m0, m1, m2, m3};
    end
  endgenerate

  assign push_data = mix_state ^ key1_reg;

  // Stage 1. alive_reg holds in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg    <= 1'b0;
      alive_reg <= 1'b0;
      sub_reg   <= '0;
      key1_reg  <= '0;
    end else begin
      alive_reg <= 1'b1;
      v1_reg    <= xfer;
      if (xfer) begin
        sub_reg  <= sub_next;
        key1_reg <= KEY1;
      end
    end
  end

  // Credit counts the block in flight as already occupying a FIFO slot, so
  // the FIFO cannot overflow even if out_ready stays low from now on.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, v1_reg};
  assign in_ready  = alive_reg && (occupancy < OW'(FIFO_DEPTH));

  round_1_enc_obuf #(
    .W     (AES_STATE_W),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (v1_reg),
    .push_data (push_data),
    .pop       (pop),
    .valid     (out_valid),
    .head      (OUT),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_round_1_enc_pipe.sv
// tb_round_1_enc_pipe
// Directed and randomized checks of round_1_enc_pipe against a reference
// model of the AES round built from its textbook definition.
module tb_round_1_enc_pipe;

  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] in_blk = '0;
  logic [127:0] key0 = '0;
  logic [127:0] key1 = '0;
  logic [127:0] out_blk;

  always #5 clk = ~clk;

  round_1_enc_pipe #(
    .BLOCK_LENGTH (128),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IN        (in_blk),
    .KEY0      (key0),
    .KEY1      (key1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (out_blk)
  );

  int           checks = 0;
  int           errors = 0;
  int           accepted = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_q [$];
  logic         hold_pending = 1'b0;
  logic [127:0] hold_val = '0;

  // Polynomial product then reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (x << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = b;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] p,
                                             input logic [127:0] k0,
                                             input logic [127:0] k1);
    logic [127:0] x;
    logic [127:0] r;
    logic [7:0]   st [4][4];
    logic [7:0]   sh [4][4];
    logic [7:0]   acc;
    int           coef [4];
    coef = '{2, 3, 1, 1};
    x = p ^ k0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        st[row][c] = sbox_tab[x[127-8*(row+4*c) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        sh[row][c] = st[row][(c+row)%4];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(8'(coef[(k-row+4)%4]), sh[k][c]);
        r[127-8*(row+4*c) -: 8] = acc;
      end
    return r ^ k1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the falling edge: scores the handshakes of the coming rising edge.
  task automatic sb_sample();
    if (hold_pending) begin
      chk("hold_valid", {127'b0, out_valid}, 128'd1);
      chk("hold_data", out_blk, hold_val);
    end
    hold_pending = out_valid && !out_ready;
    hold_val     = out_blk;
    if (!out_valid) chk("idle_zero", out_blk, 128'd0);
    if (out_valid && out_ready) begin
      chk_int("spurious_out", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("stream_data", out_blk, exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_round(in_blk, key0, key1));
      accepted++;
    end
    chk_int("occupancy_le_depth", int'(exp_q.size() <= DEPTH), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    tick();
  endtask

  task automatic randomize_inputs();
    in_blk = {$urandom, $urandom, $urandom, $urandom};
    key0   = {$urandom, $urandom, $urandom, $urandom};
    key1   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge clk);
      if (out_valid) begin
        chk(tag, out_blk, exp);
        got = 1'b1;
      end
      sb_sample();
      tick();
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s_timeout observed=no out_valid expected=out_valid within 6 cycles", tag);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) step();
    chk_int("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int n;
    build_sbox();

    // Reset state
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
    chk("reset_out", out_blk, 128'd0);
    chk("reset_in_ready", {127'b0, in_ready}, 128'd0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("ready_after_reset", {127'b0, in_ready}, 128'd1);
    tick();

    // FIPS-197 Appendix B vector with exact latency
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_blk    = 128'h3243f6a8885a308d313198a2e0370734;
    key0      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key1      = 128'ha0fafe1788542cb123a339392a6c7605;
    @(negedge clk);
    chk("fips_in_ready", {127'b0, in_ready}, 128'd1);
    sb_sample();
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_valid", {127'b0, out_valid}, 128'd0);
    sb_sample();
    tick();
    @(negedge clk);
    chk("lat_edge2_valid", {127'b0, out_valid}, 128'd1);
    chk("fips_out", out_blk, 128'ha49c7ff2689f352b6b5bea43026a5049);
    sb_sample();
    tick();
    drain();

    // All-zero vector
    in_valid = 1'b1;
    in_blk = '0; key0 = '0; key1 = '0;
    step();
    in_valid = 1'b0;
    wait_out("zero_out", 128'h63636363636363636363636363636363);
    drain();

    // Back-to-back stream of 16 blocks
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      randomize_inputs();
      @(negedge clk);
      chk("b2b_in_ready", {127'b0, in_ready}, 128'd1);
      if (i >= 2) chk("b2b_out_valid", {127'b0, out_valid}, 128'd1);
      sb_sample();
      tick();
    end
    drain();

    // Stall: exactly DEPTH blocks accepted, outputs hold
    out_ready = 1'b0;
    acc0 = accepted;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      randomize_inputs();
      step();
    end
    @(negedge clk);
    chk_int("stall_accepts", accepted - acc0, DEPTH);
    chk("stall_in_ready", {127'b0, in_ready}, 128'd0);
    sb_sample();
    tick();
    drain();

    // Random handshakes, 1000 blocks
    acc0 = accepted;
    n = 0;
    while (accepted - acc0 < 1000 && n < 8000) begin
      in_valid  = ($urandom & 1) != 0;
      out_ready = ($urandom & 1) != 0;
      randomize_inputs();
      step();
      n++;
    end
    chk_int("random_accepts", accepted - acc0, 1000);
    drain();

    // Reset with 2 blocks buffered and 1 in flight
    out_ready = 1'b0;
    acc0 = accepted;
    for (int i = 0; i < 10 && accepted - acc0 < 3; i++) begin
      in_valid = 1'b1;
      randomize_inputs();
      step();
    end
    chk_int("pre_reset_accepts", accepted - acc0, 3);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_valid", {127'b0, out_valid}, 128'd0);
    chk("async_reset_out", out_blk, 128'd0);
    exp_q.delete();
    hold_pending = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("post_reset_in_ready", {127'b0, in_ready}, 128'd1);
    chk("post_reset_no_stale", {127'b0, out_valid}, 128'd0);
    sb_sample();
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    randomize_inputs();
    acc0 = accepted;
    step();
    chk_int("post_reset_accept", accepted - acc0, 1);
    in_valid = 1'b0;
    wait_out("post_reset_out", ref_round(in_blk, key0, key1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
